// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
//   Shared definitions for the memory arbiter: FSM state encoding and the
//   default values of the arbiter parameters.
package memory_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ    = 5;
  localparam int unsigned DEF_MEM_ADDR_W = 10;
  localparam int unsigned DEF_HOLD_MAX   = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
//   Purely combinational round-robin search. Starting at i_Ptr and moving
//   upward (wrapping at NUM_REQ), the first requester with its bit set wins.
// Ports:
//   i_Request  NUM_REQ  request vector
//   i_Ptr      PTR_W    index searched first
//   o_Winner   NUM_REQ  one-hot winner (all zero when no request)
module rr_priority_picker
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_Request,
  input  logic [PTR_W-1:0]   i_Ptr,
  output logic [NUM_REQ-1:0] o_Winner
);

  logic w_Found;

  always_comb begin
    o_Winner = '0;
    w_Found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_Found && i_Request[(32'(i_Ptr) + 32'(i)) % NUM_REQ]) begin
        o_Winner[(32'(i_Ptr) + 32'(i)) % NUM_REQ] = 1'b1;
        w_Found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Round-robin arbiter giving NUM_REQ requesters (0 = main control unit,
//   1..NUM_REQ-1 = processors) access to one shared memory. IDLE picks a
//   winner, GRANT holds it while its request stays high, RELEASE is a single
//   bus-turnaround cycle before arbitrating again.
//   Optional feature: define MEMORY_ARBITER_TIMEOUT_EN to force a release
//   (with a one-cycle o_Timeout pulse) after HOLD_MAX grant cycles.
// Ports:
//   i_Clock, i_Reset_n        clock, asynchronous active-low reset
//   i_Request/o_Grant         per-requester request, registered one-hot grant
//   i_Address/i_Write_Data/i_Write_Enable  flattened per-requester bus slices
//   o_Memory_Address/o_Memory_Data/o_Write_Enable  granted slice to memory
//   i_Memory_Data/o_Read_Data memory read data, broadcast
//   o_Busy                    any grant held
//   o_Timeout                 pulse on forced release
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int unsigned HOLD_MAX   = DEF_HOLD_MAX
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic [NUM_REQ-1:0]            i_Request,
  output logic [NUM_REQ-1:0]            o_Grant,
  input  logic [NUM_REQ*MEM_ADDR_W-1:0] i_Address,
  input  logic [NUM_REQ*32-1:0]         i_Write_Data,
  input  logic [NUM_REQ-1:0]            i_Write_Enable,
  output logic [MEM_ADDR_W-1:0]         o_Memory_Address,
  output logic [31:0]                   o_Memory_Data,
  output logic                          o_Write_Enable,
  input  logic [31:0]                   i_Memory_Data,
  output logic [31:0]                   o_Read_Data,
  output logic                          o_Busy,
  output logic                          o_Timeout
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_State, w_State_Next;
  logic [NUM_REQ-1:0]   r_Grant, w_Grant_Next;
  logic [PTR_W-1:0]     r_Ptr, w_Ptr_Next;
  logic                 r_Timeout, w_Timeout_Next;
  logic [NUM_REQ-1:0]   w_Winner;
  logic [PTR_W-1:0]     w_Grant_Idx;
  logic [PTR_W-1:0]     w_Ptr_Adv;
  logic                 w_Owner_Req;
  logic                 w_Hold_Max_Hit;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_Request (i_Request),
    .i_Ptr     (r_Ptr),
    .o_Winner  (w_Winner)
  );

  // Binary index of the current holder, used to advance the pointer.
  always_comb begin
    w_Grant_Idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_Grant[i]) w_Grant_Idx = PTR_W'(i);
    end
  end

  assign w_Ptr_Adv   = (w_Grant_Idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_Grant_Idx + PTR_W'(1);
  assign w_Owner_Req = |(i_Request & r_Grant);

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  localparam int unsigned HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [HOLD_W-1:0] r_Hold, w_Hold_Next;

  assign w_Hold_Max_Hit = (r_Hold == HOLD_W'(HOLD_MAX - 1));

  // Counts completed GRANT cycles of the current holder; cleared on leaving GRANT.
  always_comb begin
    w_Hold_Next = '0;
    if (r_State == GRANT && w_State_Next == GRANT) w_Hold_Next = r_Hold + HOLD_W'(1);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) r_Hold <= '0;
    else            r_Hold <= w_Hold_Next;
  end
`else
  assign w_Hold_Max_Hit = 1'b0;
`endif

  always_comb begin
    w_State_Next   = r_State;
    w_Grant_Next   = r_Grant;
    w_Ptr_Next     = r_Ptr;
    w_Timeout_Next = 1'b0;
    unique case (r_State)
      IDLE: begin
        w_Grant_Next = '0;
        if (|i_Request) begin
          w_State_Next = GRANT;
          w_Grant_Next = w_Winner;
        end
      end
      GRANT: begin
        if (!w_Owner_Req) begin
          w_State_Next = RELEASE;
          w_Grant_Next = '0;
          w_Ptr_Next   = w_Ptr_Adv;
        end else if (w_Hold_Max_Hit) begin
          w_State_Next   = RELEASE;
          w_Grant_Next   = '0;
          w_Ptr_Next     = w_Ptr_Adv;
          w_Timeout_Next = 1'b1;
        end
      end
      RELEASE: begin
        // Turnaround cycle: pending requests wait for IDLE.
        w_State_Next = IDLE;
        w_Grant_Next = '0;
      end
      default: begin
        w_State_Next = IDLE;
        w_Grant_Next = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State   <= IDLE;
      r_Grant   <= '0;
      r_Ptr     <= '0;
      r_Timeout <= 1'b0;
    end else begin
      r_State   <= w_State_Next;
      r_Grant   <= w_Grant_Next;
      r_Ptr     <= w_Ptr_Next;
      r_Timeout <= w_Timeout_Next;
    end
  end

  // AND-OR mux over the one-hot grant; all zero when nothing is granted.
  always_comb begin
    o_Memory_Address = '0;
    o_Memory_Data    = '0;
    o_Write_Enable   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_Grant[i]) begin
        o_Memory_Address = o_Memory_Address | i_Address[i*MEM_ADDR_W +: MEM_ADDR_W];
        o_Memory_Data    = o_Memory_Data | i_Write_Data[i*32 +: 32];
        o_Write_Enable   = o_Write_Enable | i_Write_Enable[i];
      end
    end
    if (r_State != GRANT) o_Write_Enable = 1'b0;
  end

  assign o_Grant     = r_Grant;
  assign o_Busy      = |r_Grant;
  assign o_Read_Data = i_Memory_Data;
  assign o_Timeout   = r_Timeout;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Scoreboard bench for memory_arbiter. A cycle-level reference model of the
//   arbitration rules (owner / turnaround gap / round-robin pointer) pushes the
//   expected outputs of every cycle into a queue; a negedge monitor pops and
//   compares. Directed scenarios come first, then randomized traffic.
//   Build with MEMORY_ARBITER_TIMEOUT_EN to exercise the forced release with HOLD_MAX=4.
module tb_memory_arbiter;

  localparam int N  = 5;
  localparam int MW = 10;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
  localparam int HOLD  = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int HOLD  = 64;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    s_req, s_we;
  logic [MW-1:0]   s_addr [N];
  logic [31:0]     s_data [N];
  logic [31:0]     s_mem;
  logic [N*MW-1:0] w_addr_flat;
  logic [N*32-1:0] w_data_flat;

  logic [N-1:0]  o_grant;
  logic [MW-1:0] o_maddr;
  logic [31:0]   o_mdata, o_rdata;
  logic          o_we, o_busy, o_to;

  always_comb begin
    w_addr_flat = '0;
    w_data_flat = '0;
    for (int i = 0; i < N; i++) begin
      w_addr_flat[i*MW +: MW] = s_addr[i];
      w_data_flat[i*32 +: 32] = s_data[i];
    end
  end

  memory_arbiter #(
    .NUM_REQ    (N),
    .MEM_ADDR_W (MW),
    .HOLD_MAX   (HOLD)
  ) dut (
    .i_Clock          (clk),
    .i_Reset_n        (rst_n),
    .i_Request        (s_req),
    .o_Grant          (o_grant),
    .i_Address        (w_addr_flat),
    .i_Write_Data     (w_data_flat),
    .i_Write_Enable   (s_we),
    .o_Memory_Address (o_maddr),
    .o_Memory_Data    (o_mdata),
    .o_Write_Enable   (o_we),
    .i_Memory_Data    (s_mem),
    .o_Read_Data      (o_rdata),
    .o_Busy           (o_busy),
    .o_Timeout        (o_to)
  );

  typedef struct {
    logic [N-1:0]  grant;
    logic [MW-1:0] addr;
    logic [31:0]   data;
    logic          we;
    logic [31:0]   rd;
    logic          busy;
    logic          to;
  } exp_t;

  exp_t q [$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got empty queue expected an entry (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("sb_grant", o_grant, e.grant);
        chk("sb_addr", o_maddr, e.addr);
        chk("sb_data", o_mdata, e.data);
        chk("sb_we", o_we, e.we);
        chk("sb_rdata", o_rdata, e.rd);
        chk("sb_busy", o_busy, e.busy);
        chk("sb_timeout", o_to, e.to);
      end
    end
  end

  // Reference model: who owns the bus, how many cycles it has held it, whether
  // a turnaround cycle is pending, and where the round-robin search starts.
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_ptr   = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] req);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!req[m_owner] || (TO_EN && m_held == HOLD)) begin
        m_to    = req[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
        m_held  = 0;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_held  = 1;
        end
      end
    end
  endfunction

  function automatic void publish();
    exp_t e;
    e.grant = '0;
    e.addr  = '0;
    e.data  = '0;
    e.we    = 1'b0;
    if (m_owner >= 0) begin
      e.grant[m_owner] = 1'b1;
      e.addr = s_addr[m_owner];
      e.data = s_data[m_owner];
      e.we   = s_we[m_owner];
    end
    e.rd   = s_mem;
    e.busy = (m_owner >= 0);
    e.to   = m_to;
    q.push_back(e);
    mon_en = 1'b1;
  endfunction

  // Pass one edge with the inputs currently applied.
  task automatic advance();
    @(posedge clk);
    #1;
    model_step(s_req);
  endtask

  task automatic cyc(input logic [N-1:0] req);
    advance();
    s_req = req;
    s_mem = $urandom();
    publish();
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  int order [$];
  int exp_order [3] = '{1, 4, 0};
  bit act  [N];
  bit seen [N];
  int len  [N];

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] prev_g;
    int  g3_len, n_to, after3;
    bit  done3, done4, was3;

    // Reset with everything driven high: outputs must stay quiet.
    s_req = '1;
    s_we  = '1;
    s_mem = 32'h1234_5678;
    for (int i = 0; i < N; i++) begin
      s_addr[i] = MW'($urandom());
      s_data[i] = $urandom();
    end
    #12;
    chk("rst_grant", o_grant, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_we", o_we, 0);
    chk("rst_timeout", o_to, 0);
    chk("rst_addr", o_maddr, 0);
    chk("rst_rdata", o_rdata, 32'h1234_5678);
    s_req = '0;
    s_we  = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 0, three grant cycles then one turnaround.
    cyc(5'b00001);
    cyc(5'b00001);
    chk("t1_grant_latency", o_grant, 5'b00001);
    cyc(5'b00001);
    cyc(5'b00000);
    chk("t1_grant_held", o_grant, 5'b00001);
    cyc(5'b00000);
    chk("t1_release_grant", o_grant, 0);
    chk("t1_release_busy", o_busy, 0);
    cyc(5'b00000);

    // Pointer now at 1: requesters 1, 4, 0 contend, each holds two cycles.
    prev_g = '0;
    for (int c = 0; c < 40 && order.size() < 3; c++) begin
      advance();
      r = 5'b10011;
      if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
      s_req = r;
      s_mem = $urandom();
      publish();
      if (o_grant != 0 && prev_g == 0) order.push_back(idx_of(o_grant));
      prev_g = o_grant;
    end
    chk("rr_order_count", order.size(), 3);
    for (int k = 0; k < 3; k++) chk("rr_order", (k < order.size()) ? order[k] : -1, exp_order[k]);
    cyc(5'b00000);
    cyc(5'b00000);
    cyc(5'b00000);

    // Requester 2 writes; memory bus must carry its slice, then zeros.
    s_addr[2] = 10'h3A5;
    s_data[2] = 32'hDEADBEEF;
    s_we      = 5'b00100;
    cyc(5'b00100);
    cyc(5'b00100);
    chk("wr_grant", o_grant, 5'b00100);
    chk("wr_addr", o_maddr, 10'h3A5);
    chk("wr_data", o_mdata, 32'hDEADBEEF);
    chk("wr_we", o_we, 1);
    cyc(5'b00100);
    cyc(5'b00000);
    cyc(5'b00000);
    chk("wr_release_addr", o_maddr, 0);
    chk("wr_release_data", o_mdata, 0);
    chk("wr_release_we", o_we, 0);
    cyc(5'b00000);
    s_we = '0;

    // Pointer at 3: requester 3 holds (forced off when timeout is built in), 4 is pending.
    g3_len = 0;
    n_to   = 0;
    after3 = -1;
    done3  = 1'b0;
    done4  = 1'b0;
    was3   = 1'b0;
    for (int c = 0; c < 24; c++) begin
      advance();
      if (m_owner == 3) was3 = 1'b1;
      if (was3 && m_owner != 3) done3 = 1'b1;
      if (!TO_EN && m_owner == 3 && m_held >= 6) done3 = 1'b1;
      if (m_owner == 4 && m_held >= 2) done4 = 1'b1;
      r = '0;
      r[3] = !done3;
      r[4] = !done4;
      s_req = r;
      s_mem = $urandom();
      publish();
      if (o_grant == 5'b01000) g3_len++;
      if (o_to) n_to++;
      if (g3_len > 0 && after3 < 0 && o_grant != 0 && o_grant != 5'b01000) after3 = idx_of(o_grant);
    end
    chk("to_grant3_len", g3_len, TO_EN ? 4 : 6);
    chk("to_pulses", n_to, TO_EN ? 1 : 0);
    chk("to_next_winner", after3, 4);
    cyc(5'b00000);
    cyc(5'b00000);

    // Asynchronous reset in the middle of a write grant.
    s_addr[1] = 10'h155;
    s_data[1] = 32'hCAFE_0001;
    s_we      = 5'b00010;
    cyc(5'b00010);
    cyc(5'b00010);
    chk("ar_pre_grant", o_grant, 5'b00010);
    chk("ar_pre_we", o_we, 1);
    mon_en = 1'b0;
    q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", o_grant, 0);
    chk("ar_we", o_we, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_addr", o_maddr, 0);
    model_reset();
    s_req = 5'b01001;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5'b01001);
    chk("ar_first_winner", o_grant, 5'b00001);
    cyc(5'b00000);
    cyc(5'b00000);
    cyc(5'b00000);
    s_we = '0;

    // Randomized traffic: requesters hold until granted, then release after a
    // random number of grant cycles (or when forced off).
    for (int i = 0; i < N; i++) begin
      act[i]  = 1'b0;
      seen[i] = 1'b0;
      len[i]  = 1;
    end
    for (int c = 0; c < 1500; c++) begin
      advance();
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          if (m_owner == i) seen[i] = 1'b1;
          if ((m_owner == i && m_held >= len[i]) || (seen[i] && m_owner != i)) begin
            act[i]  = 1'b0;
            seen[i] = 1'b0;
          end
        end else if ($urandom_range(3) == 0) begin
          act[i]  = 1'b1;
          seen[i] = 1'b0;
          len[i]  = $urandom_range(TO_EN ? 7 : 5, 1);
        end
        s_req[i]  = act[i];
        s_we[i]   = 1'($urandom_range(1));
        s_addr[i] = MW'($urandom());
        s_data[i] = $urandom();
      end
      s_mem = $urandom();
      publish();
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
